// File: rtl/lf_seq_divider_pkg.sv
// Shared widths, state encoding and constants for the sequential divider.
package lf_pkg;
  localparam int DVD_W = 34;
  localparam int DVS_W = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DVD_W-1:0] DZ_QUOT = '1;
endpackage

// File: rtl/lf_seq_divider_prefix_sub.sv
// Combinational a-b computed as a + ~b + 1 through a Ladner-Fisher prefix carry tree.
module lf_prefix_sub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);
  localparam int LVL = $clog2(W);

  // Each level merges every odd-indexed block with the last bit of the block before it.
  function automatic logic [W-1:0] prefix_carry(input logic [W-1:0] g_in, input logic [W-1:0] p_in);
    logic [W-1:0] g, p, g_nx, p_nx;
    g = g_in;
    p = p_in;
    for (int l = 0; l < LVL; l++) begin
      g_nx = g;
      p_nx = p;
      for (int i = 0; i < W; i++) begin
        if (((i >> l) & 1) == 1) begin
          g_nx[i] = g[i] | (p[i] & g[((i >> l) << l) - 1]);
          p_nx[i] = p[i] & p[((i >> l) << l) - 1];
        end
      end
      g = g_nx;
      p = p_nx;
    end
    return g;
  endfunction

  logic [W-1:0] p_bit, g_bit, g_seed, carry;

  always_comb begin
    p_bit  = a ^ ~b;
    g_bit  = a & ~b;
    // Carry-in of 1 folds into bit 0: it generates whenever it propagates.
    g_seed = {g_bit[W-1:1], g_bit[0] | p_bit[0]};
    carry  = prefix_carry(g_seed, p_bit);
    diff   = p_bit ^ {carry[W-2:0], 1'b1};
    borrow = ~carry[W-1];
  end
endmodule

// File: rtl/lf_seq_divider.sv
// Radix-2 restoring divider with valid/ready handshakes on operand and result sides.
module lf_seq_divider
  import lf_pkg::*;
#(
  parameter int DVD_W = lf_pkg::DVD_W,
  parameter int DVS_W = lf_pkg::DVS_W,
  parameter int CNT_W = lf_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DVD_W-1:0] quot,
  output logic [DVS_W-1:0] rem,
  output logic             dz
);
  state_t           state;
  logic [DVD_W-1:0] q_sr;
  logic [DVS_W:0]   r_sr;
  logic [DVS_W-1:0] dvs;
  logic [CNT_W-1:0] cnt;

  logic [DVS_W:0]   trial, diff, r_next;
  logic             borrow, sub_ok;
  logic [DVD_W-1:0] q_next;

  assign trial = {r_sr[DVS_W-1:0], q_sr[DVD_W-1]};

  lf_prefix_sub #(.W(DVS_W + 1)) u_sub (
    .a      (trial),
    .b      ({1'b0, dvs}),
    .diff   (diff),
    .borrow (borrow)
  );

  // R stays below the divisor, so its top bit is zero; OR-ing it in keeps the full width honest.
  assign sub_ok = ~borrow | r_sr[DVS_W];
  assign r_next = sub_ok ? diff : trial;
  assign q_next = {q_sr[DVD_W-2:0], sub_ok};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      dz        <= 1'b0;
      q_sr      <= '0;
      r_sr      <= '0;
      dvs       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvs      <= divisor;
            in_ready <= 1'b0;
            if (divisor == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              quot      <= '1;
              rem       <= dividend[DVS_W-1:0];
              dz        <= 1'b1;
            end else begin
              state <= BUSY;
              q_sr  <= dividend;
              r_sr  <= '0;
              cnt   <= CNT_W'(DVD_W);
            end
          end
        end
        BUSY: begin
          r_sr <= r_next;
          q_sr <= q_next;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quot      <= q_next;
            rem       <= r_next[DVS_W-1:0];
            dz        <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lf_seq_divider.sv
// Randomized self-checking bench for lf_seq_divider against an arithmetic reference.
module tb_lf_seq_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [33:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [33:0] quot;
  logic [31:0] rem;
  logic        dz;

  int checks = 0;
  int errors = 0;

  lf_seq_divider dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] ref_quot(input logic [33:0] a, input logic [31:0] b);
    longint unsigned x, y;
    x = 64'(a);
    y = 64'(b);
    if (y == 0) return '1;
    return 34'(x / y);
  endfunction

  function automatic logic [31:0] ref_rem(input logic [33:0] a, input logic [31:0] b);
    longint unsigned x, y;
    x = 64'(a);
    y = 64'(b);
    if (y == 0) return a[31:0];
    return 32'(x % y);
  endfunction

  task automatic run_op(input logic [33:0] a, input logic [31:0] b, output int lat,
                        output logic [33:0] q, output logic [31:0] r, output logic z);
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL op_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
    q = quot;
    r = rem;
    z = dz;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [33:0] a, input logic [31:0] b,
                          input int exp_lat);
    int lat;
    logic [33:0] q;
    logic [31:0] r;
    logic z;
    run_op(a, b, lat, q, r, z);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat);
    end
    checks++;
    if (q !== ref_quot(a, b)) begin
      errors++;
      $display("FAIL %s_quot: got %h, required %h", name, q, ref_quot(a, b));
    end
    checks++;
    if (r !== ref_rem(a, b)) begin
      errors++;
      $display("FAIL %s_rem: got %h, required %h", name, r, ref_rem(a, b));
    end
    checks++;
    if (z !== (b == 0)) begin
      errors++;
      $display("FAIL %s_dz: got %0b, required %0b", name, z, (b == 0));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, quot, rem, dz} !== {1'b1, 1'b0, 34'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b quot=%h rem=%h dz=%0b, required 1 0 0 0 0",
               in_ready, out_valid, quot, rem, dz);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [33:0] q;
    logic [31:0] r;
    logic z;
    run_op(34'd100, 32'd7, lat, q, r, z);
    checks++;
    if ({q, r, z} !== {34'd14, 32'd2, 1'b0} || lat != 35) begin
      errors++;
      $display("FAIL basic_100_7: quot=%0d rem=%0d dz=%0b lat=%0d, required 14 2 0 35", q, r, z, lat);
    end
    check_op("small", 34'd12345, 32'd10, 35);
  endtask

  task automatic test_boundaries();
    int lat;
    logic [33:0] q;
    logic [31:0] r;
    logic z;
    run_op(34'h3_FFFF_FFFF, 32'd1, lat, q, r, z);
    checks++;
    if ({q, r} !== {34'h3_FFFF_FFFF, 32'd0}) begin
      errors++;
      $display("FAIL max_div_1: quot=%h rem=%h, required 3ffffffff 0", q, r);
    end
    run_op(34'h3_FFFF_FFFF, 32'hFFFF_FFFF, lat, q, r, z);
    checks++;
    if ({q, r} !== {34'd4, 32'd3}) begin
      errors++;
      $display("FAIL max_div_max: quot=%h rem=%h, required 4 3", q, r);
    end
    check_op("dvd_lt_dvs", 34'd5, 32'd9, 35);
    check_op("dvd_zero", 34'd0, 32'hDEAD_BEEF, 35);
  endtask

  task automatic test_div_zero();
    int lat;
    logic [33:0] q;
    logic [31:0] r;
    logic z;
    run_op(34'h1_2345_6789, 32'd0, lat, q, r, z);
    checks++;
    if ({q, r, z} !== {34'h3_FFFF_FFFF, 32'h2345_6789, 1'b1} || lat != 1) begin
      errors++;
      $display("FAIL div_zero: quot=%h rem=%h dz=%0b lat=%0d, required 3ffffffff 23456789 1 1",
               q, r, z, lat);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [33:0] q0;
    logic [31:0] r0;
    dividend  = 34'd1_000_003;
    divisor   = 32'd97;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    dividend = 34'd77;
    divisor  = 32'd5;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    q0 = quot;
    r0 = rem;
    checks++;
    if (q0 !== ref_quot(34'd1_000_003, 32'd97) || r0 !== ref_rem(34'd1_000_003, 32'd97)) begin
      errors++;
      $display("FAIL bp_result: quot=%0d rem=%0d, required %0d %0d", q0, r0,
               ref_quot(34'd1_000_003, 32'd97), ref_rem(34'd1_000_003, 32'd97));
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, quot, rem, dz} !== {1'b1, 1'b0, q0, r0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: out_valid=%0b in_ready=%0b quot=%0d rem=%0d, required 1 0 %0d %0d",
                 i, out_valid, in_ready, quot, rem, q0, r0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [33:0] q;
    logic [31:0] r;
    logic z;
    logic seen;
    dividend = 34'd1000;
    divisor  = 32'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, quot, rem} !== {1'b1, 1'b0, 34'd0, 32'd0}) begin
      errors++;
      $display("FAIL mid_reset: in_ready=%0b out_valid=%0b quot=%h rem=%h, required 1 0 0 0",
               in_ready, out_valid, quot, rem);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_no_result: out_valid seen=%0b, required 0", seen);
    end
    run_op(34'd9, 32'd3, lat, q, r, z);
    checks++;
    if ({q, r} !== {34'd3, 32'd0}) begin
      errors++;
      $display("FAIL after_reset_9_3: quot=%0d rem=%0d, required 3 0", q, r);
    end
  endtask

  task automatic test_back_to_back();
    localparam int NOPS = 1000;
    logic [33:0] qa[$];
    logic [31:0] qb[$];
    logic [33:0] ea;
    logic [31:0] eb;
    int sent = 0, done = 0, cycle = 0, last_fin = -1;
    logic acc, fin;
    longint unsigned prod;

    dividend  = {2'($urandom_range(0, 3)), 32'($urandom)};
    divisor   = 32'($urandom) >> $urandom_range(0, 31);
    if (divisor == 0) divisor = 32'd1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (done < NOPS && cycle < 50000) begin
      acc = in_valid && in_ready;
      fin = out_valid && out_ready;
      if (acc) begin
        qa.push_back(dividend);
        qb.push_back(divisor);
      end
      if (fin) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        checks++;
        if (quot !== ref_quot(ea, eb) || rem !== ref_rem(ea, eb) || dz !== 1'b0) begin
          errors++;
          $display("FAIL b2b_result %0d: %h/%h got quot=%h rem=%h dz=%0b, required %h %h 0",
                   done, ea, eb, quot, rem, dz, ref_quot(ea, eb), ref_rem(ea, eb));
        end
        prod = 64'(quot) * 64'(eb) + 64'(rem);
        checks++;
        if (prod != 64'(ea) || 64'(rem) >= 64'(eb)) begin
          errors++;
          $display("FAIL b2b_invariant %0d: quot*dvs+rem=%h rem=%h, required %h with rem<%h",
                   done, prod, rem, ea, eb);
        end
        if (last_fin >= 0) begin
          checks++;
          if (cycle + 1 - last_fin != 36) begin
            errors++;
            $display("FAIL b2b_spacing %0d: got %0d cycles, required 36", done, cycle + 1 - last_fin);
          end
        end
        last_fin = cycle + 1;
        done++;
      end
      @(posedge clk); #1;
      cycle++;
      if (acc) begin
        sent++;
        if (sent < NOPS) begin
          dividend = {2'($urandom_range(0, 3)), 32'($urandom)};
          divisor  = 32'($urandom) >> $urandom_range(0, 31);
          if (divisor == 0) divisor = 32'd1;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (done != NOPS) begin
      errors++;
      $display("FAIL b2b_complete: got %0d results, required %0d", done, NOPS);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
